// File: rtl/matmul2_pkg.sv
// Shared definitions for the 2x2 sequential matrix multiplier: FSM encoding,
// element indices and the row/column helpers used to walk the operands.
package matmul2_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    // Element order inside a packed matrix.
    localparam logic [1:0] ElemR0C0 = 2'd0;
    localparam logic [1:0] ElemR0C1 = 2'd1;
    localparam logic [1:0] ElemR1C0 = 2'd2;
    localparam logic [1:0] ElemR1C1 = 2'd3;

    function automatic logic row_of(input logic [1:0] elem);
        return elem[1];
    endfunction

    function automatic logic col_of(input logic [1:0] elem);
        return elem[0];
    endfunction

endpackage

// File: rtl/sat_trunc.sv
// Reduces a wide signed accumulator to the element width, flagging values that do not fit.
// Clamps when MATMUL2_SAT_EN is defined, otherwise keeps the low bits.
module sat_trunc #(
    parameter int unsigned IN_W  = 19,
    parameter int unsigned OUT_W = 9
) (
    input  logic [IN_W-1:0]  in_val,
    output logic [OUT_W-1:0] out_val,
    output logic             ovf
);

    logic [IN_W-OUT_W:0] upper;

    // The value fits only if every bit from the output sign bit upward is identical.
    assign upper = in_val[IN_W-1:OUT_W-1];
    assign ovf   = !((&upper) || !(|upper));

`ifdef MATMUL2_SAT_EN
    always_comb begin
        out_val = in_val[OUT_W-1:0];
        if (ovf) begin
            out_val = in_val[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
`else
    assign out_val = in_val[OUT_W-1:0];
`endif

endmodule

// File: rtl/matmul2_seq.sv
// Sequential 2x2 signed matrix multiply, one product per cycle on a single multiplier.
// Define MATMUL2_SAT_EN to saturate out-of-range elements instead of wrapping them.
module matmul2_seq
    import matmul2_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [4*(DATA_WIDTH+1)-1:0]   a_flat,
    input  logic [4*(DATA_WIDTH+1)-1:0]   b_flat,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [4*(DATA_WIDTH+1)-1:0]   c_flat,
    output logic                          overflow
);

    localparam int unsigned W  = DATA_WIDTH + 1;
    localparam int unsigned AW = 2 * W + 1;

    state_e              state_q, state_d;
    logic [2:0]          k_q, k_d;
    logic [AW-1:0]       acc_q, acc_d;
    logic [4*W-1:0]      a_q, a_d;
    logic [4*W-1:0]      b_q, b_d;
    logic [4*W-1:0]      c_q, c_d;
    logic                ovf_q, ovf_d;

    logic [1:0]          elem;
    logic                j;
    logic [1:0]          a_idx;
    logic [1:0]          b_idx;
    logic signed [W-1:0]   a_op;
    logic signed [W-1:0]   b_op;
    logic signed [2*W-1:0] prod;
    logic [AW-1:0]       sum;
    logic [W-1:0]        red;
    logic                red_ovf;

    // k[2:1] selects the output element, k[0] the inner-product term.
    assign elem  = k_q[2:1];
    assign j     = k_q[0];
    assign a_idx = {row_of(elem), j};
    assign b_idx = {j, col_of(elem)};
    assign a_op  = a_q[int'(a_idx)*W +: W];
    assign b_op  = b_q[int'(b_idx)*W +: W];
    assign prod  = a_op * b_op;
    assign sum   = acc_q + {prod[2*W-1], prod};

    sat_trunc #(
        .IN_W  (AW),
        .OUT_W (W)
    ) u_sat_trunc (
        .in_val  (sum),
        .out_val (red),
        .ovf     (red_ovf)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a_flat;
                    b_d     = b_flat;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    k_d     = 3'd0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                k_d = k_q + 3'd1;
                if (!j) begin
                    acc_d = sum;
                end else begin
                    acc_d                  = '0;
                    c_d[int'(elem)*W +: W] = red;
                    ovf_d                  = ovf_q | red_ovf;
                    if (elem == ElemR1C1) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            k_q     <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign c_flat    = c_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_matmul2_seq.sv
// Directed self-checking bench for matmul2_seq at DATA_WIDTH=8 (W=9).
// Expected values follow the build: MATMUL2_SAT_EN selects the saturating result.
module tb_matmul2_seq;

    localparam int unsigned DW = 8;
    localparam int unsigned W  = DW + 1;
    localparam int unsigned CW = 4 * W;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] a_flat;
    logic [CW-1:0] b_flat;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] c_flat;
    logic          overflow;

    int vectors;
    int miscompares;

    matmul2_seq #(
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_flat    (a_flat),
        .b_flat    (b_flat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c_flat    (c_flat),
        .overflow  (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] pack4(input int e0, input int e1, input int e2,
                                            input int e3);
        logic [CW-1:0] r;
        int            v[4];
        v = '{e0, e1, e2, e3};
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i*W +: W] = v[i][W-1:0];
        end
        return r;
    endfunction

    // One full transaction from IDLE; optionally stalls the consumer for 'hold' cycles.
    task automatic run_txn(input string tag, input logic [CW-1:0] a, input logic [CW-1:0] b,
                           input logic [CW-1:0] exp_c, input logic exp_ovf, input int hold);
        a_flat    = a;
        b_flat    = b;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        check({tag, "_in_ready_idle"}, in_ready, 1);
        step();
        in_valid = 1'b0;
        check({tag, "_in_ready_calc"}, in_ready, 0);
        for (int e = 2; e <= 8; e++) step();
        check({tag, "_out_valid_early"}, out_valid, 0);
        step();
        check({tag, "_out_valid"}, out_valid, 1);
        check({tag, "_c_flat"}, c_flat, exp_c);
        check({tag, "_overflow"}, overflow, exp_ovf);
        in_valid = (hold > 0);
        for (int h = 0; h < hold; h++) begin
            step();
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_c"}, c_flat, exp_c);
            check({tag, "_hold_ovf"}, overflow, exp_ovf);
            check({tag, "_hold_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, "_release_valid"}, out_valid, 0);
        check({tag, "_release_in_ready"}, in_ready, 1);
    endtask

    logic [CW-1:0] a1, b1, c1, a2, b2, c2, a3, b3, c3;

    initial begin
        vectors     = 0;
        miscompares = 0;
        a1 = pack4(1, 2, 3, 4);
        b1 = pack4(5, 6, 7, 8);
        c1 = pack4(19, 22, 43, 50);
        a2 = pack4(3, -1, -5, 2);
        b2 = pack4(2, 1, 5, 3);
        c2 = pack4(1, 0, 0, 1);
        a3 = pack4(255, 255, 0, 0);
        b3 = pack4(255, 0, 255, 0);
`ifdef MATMUL2_SAT_EN
        c3 = pack4(255, 0, 0, 0);
`else
        c3 = pack4(2, 0, 0, 0);
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_flat    = '0;
        b_flat    = '0;
        step();
        step();
        rst = 1'b0;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_c_flat", c_flat, 0);
        check("reset_overflow", overflow, 0);

        run_txn("basic", a1, b1, c1, 1'b0, 0);
        run_txn("inverse", a2, b2, c2, 1'b0, 0);
        run_txn("ovf", a3, b3, c3, 1'b1, 0);
        run_txn("hold", a1, b1, c1, 1'b0, 5);

        // Abort a transaction at k=4, after c00 has already overflowed.
        a_flat   = a3;
        b_flat   = b3;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int e = 1; e <= 4; e++) step();
        check("midrst_ovf_before", overflow, 1);
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_c_flat", c_flat, 0);
        check("midrst_overflow", overflow, 0);
        run_txn("post_rst", a1, b1, c1, 1'b0, 0);

        // Back-to-back with in_valid and out_ready held high.
        a_flat    = a3;
        b_flat    = b3;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        a_flat = a1;
        b_flat = b1;
        check("b2b_t1_accept", in_ready, 0);
        for (int e = 2; e <= 8; e++) step();
        check("b2b_t1_early", out_valid, 0);
        step();
        check("b2b_t1_valid", out_valid, 1);
        check("b2b_t1_c", c_flat, c3);
        check("b2b_t1_ovf", overflow, 1);
        step();
        check("b2b_gap_in_ready", in_ready, 1);
        check("b2b_gap_out_valid", out_valid, 0);
        step();
        check("b2b_t2_accept", in_ready, 0);
        check("b2b_t2_ovf_clear", overflow, 0);
        for (int e = 2; e <= 8; e++) step();
        check("b2b_t2_early", out_valid, 0);
        step();
        check("b2b_t2_valid", out_valid, 1);
        check("b2b_t2_c", c_flat, c1);
        check("b2b_t2_ovf", overflow, 0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/matmul2_seq.md
MATMUL2_SEQ -- requirements
Module: matmul2_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8; element width W = DATA_WIDTH+1 bits, signed two's complement.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, operand pair present.
REQ-005 SHALL have port in_ready, output, 1, block can accept operands.
REQ-006 SHALL have port a_flat, input, 4*W, matrix A; element i at bits [i*W +: W], order 0=r0c0, 1=r0c1, 2=r1c0, 3=r1c1.
REQ-007 SHALL have port b_flat, input, 4*W, matrix B, same packing.
REQ-008 SHALL have port out_valid, output, 1, result present.
REQ-009 SHALL have port out_ready, input, 1, consumer takes result.
REQ-010 SHALL have port c_flat, output, 4*W, C = A*B, same packing.
REQ-011 SHALL have port overflow, output, 1, at least one element of C did not fit in W bits.

Function
REQ-012 SHALL use an FSM with states IDLE, CALC, DONE.
REQ-013 SHALL drive in_ready=1 only in IDLE.
REQ-014 SHALL, in IDLE with in_valid=1, register A and B, clear the accumulator, clear overflow, set k=0 and enter CALC.
REQ-015 SHALL compute one signed product per CALC cycle with a single multiplier, 8 cycles, k=0..7: element i=k>>1, product A[row(i),k&1]*B[k&1,col(i)].
REQ-016 SHALL accumulate at 2W+1 bits; on odd k, reduce the accumulator to W bits per REQ-026/027, write C[i], and clear the accumulator.
REQ-017 SHALL enter DONE after k=7 and assert out_valid in the 9th cycle after the accept edge.
REQ-018 SHALL hold out_valid, c_flat and overflow stable in DONE until out_ready=1, then return to IDLE on that edge.
REQ-019 SHALL NOT accept new operands in the DONE-to-IDLE cycle; minimum issue interval is 10 cycles.
REQ-020 SHALL ignore in_valid in CALC and DONE, and ignore out_ready outside DONE.
REQ-021 SHALL make overflow sticky for one transaction: set if any element overflows, cleared on the next accept.

Reset
REQ-022 SHALL, with rst=1 on an edge, force IDLE, in_ready=1, out_valid=0, c_flat=0, overflow=0, k=0, accumulator=0.
REQ-023 SHALL abandon any in-flight transaction on reset; no partial result appears.
REQ-024 SHALL give rst priority over in_valid and out_ready on the same edge.

Configuration
REQ-025 SHALL have exactly one option, macro MATMUL2_SAT_EN.
REQ-026 SHALL, with MATMUL2_SAT_EN defined, clamp each out-of-range element to +(2^(W-1)-1) or -2^(W-1).
REQ-027 SHALL, without MATMUL2_SAT_EN, wrap each element to its low W bits; overflow is flagged identically in both builds.

Structure
REQ-028 SHALL place the FSM state encoding, the element-index constants and the row/col index functions in package matmul2_pkg.
REQ-029 SHALL place the 2W+1-to-W reduction (saturate/wrap plus overflow detect) in sub-module sat_trunc; the multiplier and accumulator stay inline.

Verification (DATA_WIDTH=8, W=9)
REQ-030 SHALL cover: A=[1,2;3,4], B=[5,6;7,8] -> C=[19,22;43,50], overflow=0, out_valid 9 cycles after accept.
REQ-031 SHALL cover: A=[3,-1;-5,2], B=[2,1;5,3] (its inverse) -> C=[1,0;0,1], overflow=0.
REQ-032 SHALL cover: A=[255,255;0,0], B=[255,0;255,0] -> c00=255 with SAT_EN, c00=2 without; other elements 0; overflow=1 in both builds.
REQ-033 SHALL cover: out_ready held low 5 cycles in DONE -> out_valid=1, c_flat and overflow constant, in_ready=0 throughout; release -> IDLE next cycle.
REQ-034 SHALL cover: rst pulsed at CALC k=4 -> next cycle out_valid=0, in_ready=1, c_flat=0, overflow=0; a fresh transaction then completes correctly.
REQ-035 SHALL cover: back-to-back transactions with in_valid held high and out_ready=1 -> accepts 10 cycles apart; overflow from transaction 1 (REQ-032) cleared for transaction 2 (REQ-030).
